// File: rtl/tanswer_pkg.sv
// Shared types and widths for the task_5 answer collector.
// Optional checksum build: define TANSWER_CHECKSUM_EN.
package tanswer_pkg;
   localparam int BYTE_W = 8;
   localparam int LEN_W  = 12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_FLUSH
   } state_t;
endpackage

// File: rtl/tanswer_if.sv
// Downstream byte port of the answer collector (FWFT head + sink ready).
interface tanswer_if;
   import tanswer_pkg::*;

   logic              o_byte_valid;
   logic [BYTE_W-1:0] o_byte;
   logic              o_byte_last;
   logic              i_byte_ready;

   modport master (
      output o_byte_valid,
      output o_byte,
      output o_byte_last,
      input  i_byte_ready
   );

   modport slave (
      input  o_byte_valid,
      input  o_byte,
      input  o_byte_last,
      output i_byte_ready
   );
endinterface

// File: rtl/tanswer_fifo.sv
// First-word-fall-through sync FIFO with occupancy count.
// A write into a full FIFO succeeds when a read frees the slot in the same cycle.
module tanswer_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 9,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);
   logic [W-1:0]    mem [DEPTH];
   logic [CW-2:0]   wr_ptr, rd_ptr;
   logic            do_rd, do_wr;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/tanswer_collector.sv
// Answer collector: buffers a whole packet, checks its length, forwards bytes.
// Define TANSWER_CHECKSUM_EN to append a per-packet XOR byte after the data.
module tanswer_collector
   import tanswer_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int MAX_PKT = 4095
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tanswer_ready,
   input  logic [BYTE_W-1:0] i_tanswer_data,
   input  logic              i_tanswer_data_last,
   input  logic [LEN_W-1:0]  i_packet_size_in_bytes,
   output logic              o_tmanager_ready,
   tanswer_if.master         sink,
   output logic              o_pkt_done,
   output logic [LEN_W-1:0]  o_pkt_len,
   output logic              o_len_error,
   output logic              o_overflow
);
   localparam int CW = $clog2(DEPTH) + 1;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  cnt, plen;
   logic              accept, acc_last, pop, at_max;
   logic              wr_en, wr_ok, pend_nxt, enter_flush;
   logic [BYTE_W:0]   wr_data, head;
   logic              f_empty, f_full;
   logic [CW-1:0]     f_count, cnt_nxt;

   assign accept   = i_tanswer_ready & o_tmanager_ready;
   assign acc_last = accept & i_tanswer_data_last;
   assign pop      = sink.o_byte_valid & sink.i_byte_ready;
   assign at_max   = (cnt == LEN_W'(MAX_PKT));
   assign plen     = at_max ? cnt : cnt + 1'b1;
   assign wr_ok    = wr_en & (~f_full | pop);
   assign cnt_nxt  = f_count + CW'(wr_ok) - CW'(pop);

   assign sink.o_byte_valid = ~f_empty;
   assign sink.o_byte       = head[BYTE_W-1:0];
   assign sink.o_byte_last  = head[BYTE_W];

   tanswer_fifo #(
      .DEPTH (DEPTH),
      .W     (BYTE_W + 1)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (f_empty),
      .full    (f_full),
      .count   (f_count)
   );

`ifdef TANSWER_CHECKSUM_EN
   logic              csum_pend, csum_wr;
   logic [BYTE_W-1:0] csum;

   // Checksum goes in after the data; the packet only enters flush once it is stored.
   assign csum_wr     = csum_pend & (~f_full | pop);
   assign wr_en       = accept | csum_wr;
   assign wr_data     = csum_pend ? {1'b1, csum} : {1'b0, i_tanswer_data};
   assign pend_nxt    = acc_last | (csum_pend & ~csum_wr);
   assign enter_flush = csum_wr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         csum_pend <= 1'b0;
         csum      <= '0;
      end else if (csum_wr) begin
         csum_pend <= 1'b0;
         csum      <= '0;
      end else if (accept) begin
         csum <= csum ^ i_tanswer_data;
         if (i_tanswer_data_last) csum_pend <= 1'b1;
      end
   end
`else
   assign wr_en       = accept;
   assign wr_data     = {i_tanswer_data_last, i_tanswer_data};
   assign pend_nxt    = 1'b0;
   assign enter_flush = acc_last;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (enter_flush)  state_nxt = S_FLUSH;
            else if (accept)  state_nxt = S_RECV;
         end
         S_RECV: begin
            if (enter_flush)  state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (pop & sink.o_byte_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state            <= S_IDLE;
         o_tmanager_ready <= 1'b0;
      end else begin
         state            <= state_nxt;
         o_tmanager_ready <= (state_nxt != S_FLUSH) & ~pend_nxt &
                             (cnt_nxt < CW'(DEPTH - 1));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt         <= '0;
         o_pkt_done  <= 1'b0;
         o_pkt_len   <= '0;
         o_len_error <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         o_pkt_done <= acc_last;
         if (accept) begin
            if (at_max) o_overflow <= 1'b1;
            if (i_tanswer_data_last) begin
               o_pkt_len   <= plen;
               o_len_error <= (plen != i_packet_size_in_bytes);
               cnt         <= '0;
            end else begin
               cnt <= plen;
            end
         end
      end
   end
endmodule

// File: tb/tb_tanswer_collector.sv
// Directed + randomized bench for tanswer_collector against a queue model.
// Define TANSWER_CHECKSUM_EN for both DUT and bench to cover the checksum build.
module tb_tanswer_collector;
   import tanswer_pkg::*;

   localparam int DEPTH   = 16;
   localparam int MAX_PKT = 4095;
`ifdef TANSWER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_tanswer_ready;
   logic [BYTE_W-1:0] i_tanswer_data;
   logic              i_tanswer_data_last;
   logic [LEN_W-1:0]  i_packet_size_in_bytes;
   logic              o_tmanager_ready;
   logic              o_pkt_done;
   logic [LEN_W-1:0]  o_pkt_len;
   logic              o_len_error;
   logic              o_overflow;

   tanswer_if sink ();

   tanswer_collector #(
      .DEPTH   (DEPTH),
      .MAX_PKT (MAX_PKT)
   ) dut (
      .i_clk                  (i_clk),
      .i_rst                  (i_rst),
      .i_tanswer_ready        (i_tanswer_ready),
      .i_tanswer_data         (i_tanswer_data),
      .i_tanswer_data_last    (i_tanswer_data_last),
      .i_packet_size_in_bytes (i_packet_size_in_bytes),
      .o_tmanager_ready       (o_tmanager_ready),
      .sink                   (sink),
      .o_pkt_done             (o_pkt_done),
      .o_pkt_len              (o_pkt_len),
      .o_len_error            (o_len_error),
      .o_overflow             (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   int pass_cnt = 0;
   int total    = 0;

   // Source words: {last, size[11:0], data[7:0]}
   logic [20:0] src_q  [$];
   logic [8:0]  exp_q  [$];
   logic [12:0] done_q [$];
   int          m_cnt;
   logic [7:0]  m_xor;
   bit          m_flush;
   bit          m_ovf;
   bit          rdy_chk;
   int          sink_mode;
   int          src_pct;
   int          accepts = 0;
   int          a0;
   int          guard;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      total++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic push_pkt(input int n, input int size, input bit rnd,
                           input logic [7:0] base);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = rnd ? 8'($urandom) : 8'(base + 8'(i));
         src_q.push_back({(i == n - 1), 12'(size), d});
      end
   endtask

   task automatic model_accept(input logic [20:0] w);
      logic [7:0]  d;
      logic        last;
      logic [11:0] sz;
      d    = w[7:0];
      sz   = w[19:8];
      last = w[20];
      accepts++;
      if (m_cnt == MAX_PKT) m_ovf = 1'b1;
      else m_cnt++;
      m_xor ^= d;
      exp_q.push_back({last & !CS, d});
      if (last) begin
         done_q.push_back({(12'(m_cnt) != sz), 12'(m_cnt)});
         if (CS) exp_q.push_back({1'b1, m_xor});
         m_cnt   = 0;
         m_xor   = '0;
         m_flush = 1'b1;
      end
   endtask

   task automatic apply();
      bit v;
      v = (src_q.size() > 0) && ($urandom_range(0, 99) < src_pct);
      if (v) begin
         {i_tanswer_data_last, i_packet_size_in_bytes, i_tanswer_data} = src_q[0];
         i_tanswer_ready = 1'b1;
      end else begin
         i_tanswer_ready        = 1'b0;
         i_tanswer_data         = 8'($urandom);
         i_tanswer_data_last    = 1'($urandom);
         i_packet_size_in_bytes = 12'($urandom);
      end
      case (sink_mode)
         0:       sink.i_byte_ready = 1'b1;
         1:       sink.i_byte_ready = 1'b0;
         default: sink.i_byte_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Called at a falling edge with inputs applied; checks, updates model, advances.
   task automatic tick();
      bit         acc, pop;
      logic [8:0] e;
      acc = i_tanswer_ready && o_tmanager_ready;
      pop = sink.o_byte_valid && sink.i_byte_ready;
      if (rdy_chk)
         check("tmanager_ready", o_tmanager_ready,
               !m_flush && (exp_q.size() < DEPTH - 1));
      check("overflow", o_overflow, m_ovf);
      if (pop) begin
         check("byte_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_byte", {sink.o_byte_last, sink.o_byte}, e);
            if (e[8]) m_flush = 1'b0;
         end
      end
      if (o_pkt_done) begin
         check("done_expected", done_q.size() > 0, 1);
         if (done_q.size() > 0)
            check("pkt_len_err", {o_len_error, o_pkt_len}, done_q.pop_front());
      end
      if (acc) model_accept(src_q.pop_front());
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic run(input int budget);
      int n;
      n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0 || done_q.size() > 0)
             && n < budget) begin
         apply();
         tick();
         n++;
      end
      check("drain_in_budget", n < budget, 1);
   endtask

   task automatic do_reset();
      i_rst             = 1'b1;
      i_tanswer_ready   = 1'b0;
      sink.i_byte_ready = 1'b0;
      #1;
      check("rst_ready", o_tmanager_ready, 0);
      check("rst_valid", sink.o_byte_valid, 0);
      check("rst_done", o_pkt_done, 0);
      check("rst_len", o_pkt_len, 0);
      check("rst_err", o_len_error, 0);
      check("rst_ovf", o_overflow, 0);
      src_q.delete();
      exp_q.delete();
      done_q.delete();
      m_cnt   = 0;
      m_xor   = '0;
      m_flush = 1'b0;
      m_ovf   = 1'b0;
      rdy_chk = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      apply();
      tick();
      check("ready_after_reset", o_tmanager_ready, 1);
      rdy_chk = 1'b1;
   endtask

   initial begin
      i_rst                  = 1'b0;
      i_tanswer_ready        = 1'b0;
      i_tanswer_data         = '0;
      i_tanswer_data_last    = 1'b0;
      i_packet_size_in_bytes = '0;
      sink.i_byte_ready      = 1'b0;
      sink_mode              = 0;
      src_pct                = 100;
      #2;
      do_reset();

      // 5-byte packet 01..05, size 5
      push_pkt(5, 5, 1'b0, 8'h01);
      run(200);

      // short packet flags error, next correct packet clears it
      push_pkt(3, 4, 1'b0, 8'h10);
      run(200);
      push_pkt(4, 4, 1'b0, 8'h20);
      run(200);
      check("err_cleared", o_len_error, 0);

      // sink stalled while 20 bytes are offered
      sink_mode = 1;
      a0 = accepts;
      push_pkt(20, 20, 1'b1, 8'h00);
      repeat (20) begin
         apply();
         tick();
      end
      check("accepted_before_stall", accepts - a0, DEPTH - 1);
      check("ready_low_stalled", o_tmanager_ready, 0);
      sink_mode = 0;
      run(300);

      // back-to-back packets with a random sink
      sink_mode = 2;
      push_pkt(6, 6, 1'b1, 8'h00);
      push_pkt(5, 5, 1'b1, 8'h00);
      run(500);

      // reset after three bytes of a packet
      sink_mode = 1;
      a0 = accepts;
      guard = 0;
      push_pkt(6, 6, 1'b1, 8'h00);
      while (accepts - a0 < 3 && guard < 50) begin
         apply();
         tick();
         guard++;
      end
      check("three_accepted", accepts - a0, 3);
      do_reset();
      repeat (3) begin
         apply();
         tick();
      end
      sink_mode = 0;
      push_pkt(2, 2, 1'b1, 8'h00);
      run(200);
      check("len_after_reset", o_pkt_len, 2);

      // announced size zero
      push_pkt(3, 0, 1'b1, 8'h00);
      run(200);
      check("size_zero_err", o_len_error, 1);

      // checksum example packet 12,34
      src_q.push_back({1'b0, 12'd2, 8'h12});
      src_q.push_back({1'b1, 12'd2, 8'h34});
      run(200);

      // randomized packets, random upstream gaps and sink
      sink_mode = 2;
      src_pct   = 70;
      for (int p = 0; p < 14; p++) begin
         int n;
         n = $urandom_range(1, 24);
         push_pkt(n, ($urandom_range(0, 2) != 0) ? n : $urandom_range(0, 30),
                  1'b1, 8'h00);
      end
      run(4000);

      // saturating count and sticky overflow
      sink_mode = 0;
      src_pct   = 100;
      push_pkt(MAX_PKT + 2, 100, 1'b1, 8'h00);
      run(10000);
      check("overflow_set", o_overflow, 1);
      check("len_saturated", o_pkt_len, MAX_PKT);
      push_pkt(3, 3, 1'b1, 8'h00);
      run(200);
      check("overflow_sticky", o_overflow, 1);
      check("err_after_ovf", o_len_error, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
